// File: rtl/dec2to4_hold_pkg.sv
// Shared types, code constants and the 4-to-2 encoder equations for the
// sequential 2-to-4 decoder and its loopback partner.
package dec_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [1:0] CODE_Y0 = 2'd0;
  localparam logic [1:0] CODE_Y1 = 2'd1;
  localparam logic [1:0] CODE_Y2 = 2'd2;
  localparam logic [1:0] CODE_Y3 = 2'd3;

  // Priority encoder equations: a1 = y3|y2, a0 = y3|(y1&~y2).
  function automatic logic [1:0] encode4to2(input logic [3:0] y);
    return {y[3] | y[2], y[3] | (y[1] & ~y[2])};
  endfunction

endpackage

// File: rtl/dec2to4_hold_if.sv
// Bus between a code source (master) and the 2-to-4 decoder (slave).
// loopback_ok is present only when DEC2TO4_LOOPBACK_EN is defined.
interface dec2to4_hold_if;
  import dec_pkg::*;

  // Handshake: a code {a1,a0} is consumed on a rising edge where
  // in_valid && in_ready; while in_ready=0 the source must hold the code.
  logic   a0;
  logic   a1;
  logic   in_valid;
  logic   in_ready;
  logic   y0;
  logic   y1;
  logic   y2;
  logic   y3;
  logic   busy;
  logic   hold_done;
  state_e dbg_state;
`ifdef DEC2TO4_LOOPBACK_EN
  logic   loopback_ok;
`endif

  modport master (
    output a0, a1, in_valid,
    input  in_ready, y0, y1, y2, y3, busy, hold_done, dbg_state
`ifdef DEC2TO4_LOOPBACK_EN
    , input loopback_ok
`endif
  );

  modport slave (
    input  a0, a1, in_valid,
    output in_ready, y0, y1, y2, y3, busy, hold_done, dbg_state
`ifdef DEC2TO4_LOOPBACK_EN
    , output loopback_ok
`endif
  );

endinterface

// File: rtl/dec2to4_hold_comb.sv
// Pure combinational 2-to-4 decode of a code into a one-hot vector.
module dec2to4_comb
  import dec_pkg::*;
(
  input  logic [1:0] code_i,
  output logic [3:0] onehot_o
);

  always_comb begin
    onehot_o = 4'b0000;
    case (code_i)
      CODE_Y0: onehot_o = 4'b0001;
      CODE_Y1: onehot_o = 4'b0010;
      CODE_Y2: onehot_o = 4'b0100;
      CODE_Y3: onehot_o = 4'b1000;
      default: onehot_o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/dec2to4_hold.sv
// Sequential 2-to-4 decoder: holds the decoded one-hot line for HOLD_CYCLES
// clocks per accepted code. Optional DEC2TO4_LOOPBACK_EN adds loopback_ok.
module dec2to4_hold
  import dec_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input logic            clk,
  input logic            rst,
  dec2to4_hold_if.slave  bus
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       code_q, code_d;
  logic [3:0]       y_q, y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [1:0] code_in;
  logic [3:0] onehot_in;
  logic       in_ready;
  logic       accept;

  assign code_in  = {bus.a1, bus.a0};
  assign in_ready = (state_q == ST_IDLE) || (cnt_q == '0);
  assign accept   = bus.in_valid && in_ready;

  dec2to4_comb u_comb (
    .code_i   (code_in),
    .onehot_o (onehot_in)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_HOLD;
          cnt_d   = RELOAD;
          code_d  = code_in;
          y_d     = onehot_in;
          busy_d  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (accept) begin
          // Back-to-back reload: the line switches in one edge, never two high.
          cnt_d  = RELOAD;
          code_d = code_in;
          y_d    = onehot_in;
        end else begin
          state_d = ST_IDLE;
          y_d     = 4'b0000;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        y_d     = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

`ifdef DEC2TO4_LOOPBACK_EN
  logic lb_q, lb_d;
  // Evaluated on next-state values so loopback_ok lines up with the held line.
  assign lb_d = busy_d && (encode4to2(y_d) == code_d);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      code_q  <= 2'd0;
      y_q     <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DEC2TO4_LOOPBACK_EN
      lb_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DEC2TO4_LOOPBACK_EN
      lb_q    <= lb_d;
      if (busy_q) assert (encode4to2(y_q) == code_q);
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.y0        = y_q[0];
  assign bus.y1        = y_q[1];
  assign bus.y2        = y_q[2];
  assign bus.y3        = y_q[3];
  assign bus.busy      = busy_q;
  assign bus.hold_done = done_q;
  assign bus.dbg_state = state_q;
`ifdef DEC2TO4_LOOPBACK_EN
  assign bus.loopback_ok = lb_q;
`endif

endmodule

// File: tb/tb_dec2to4_hold.sv
// Bench for dec2to4_hold: one instance with HOLD_CYCLES=4 and one with
// HOLD_CYCLES=1, directed scenarios then randomized traffic against a model.
module tb_dec2to4_hold;
  import dec_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Per-instance stimulus: index 0 -> HOLD_CYCLES=4, index 1 -> HOLD_CYCLES=1
  logic       v[2];
  logic [1:0] c[2];

  dec2to4_hold_if if4 ();
  dec2to4_hold_if if1 ();

  assign if4.in_valid = v[0];
  assign if4.a0       = c[0][0];
  assign if4.a1       = c[0][1];
  assign if1.in_valid = v[1];
  assign if1.a0       = c[1][0];
  assign if1.a1       = c[1][1];

  dec2to4_hold #(.HOLD_CYCLES(4), .CNT_W(8)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  dec2to4_hold #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  logic [3:0] yv[2];
  logic       rdy[2];
  logic       bsy[2];
  logic       hd[2];
  assign yv[0]  = {if4.y3, if4.y2, if4.y1, if4.y0};
  assign yv[1]  = {if1.y3, if1.y2, if1.y1, if1.y0};
  assign rdy[0] = if4.in_ready;
  assign rdy[1] = if1.in_ready;
  assign bsy[0] = if4.busy;
  assign bsy[1] = if1.busy;
  assign hd[0]  = if4.hold_done;
  assign hd[1]  = if1.hold_done;
`ifdef DEC2TO4_LOOPBACK_EN
  logic lb[2];
  assign lb[0] = if4.loopback_ok;
  assign lb[1] = if1.loopback_ok;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // rem = cycles the current line is still to be shown (including this one).
  int  hold_len[2] = '{4, 1};
  int  rem[2]      = '{0, 0};
  int  code_m[2]   = '{0, 0};
  bit  done_m[2]   = '{0, 0};
  bit  acc_m[2]    = '{0, 0};
  bit  started     = 0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        rem[i]    = 0;
        done_m[i] = 0;
        acc_m[i]  = 0;
      end else begin
        acc_m[i] = v[i] && (rem[i] <= 1);
        if (acc_m[i]) begin
          code_m[i] = int'(c[i]);
          rem[i]    = hold_len[i];
          done_m[i] = 0;
        end else if (rem[i] > 0) begin
          rem[i]    = rem[i] - 1;
          done_m[i] = (rem[i] == 0);
        end else begin
          done_m[i] = 0;
        end
      end
    end
    started = 1;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        logic [3:0] exp_y;
        exp_y = (rem[i] > 0) ? 4'(1 << code_m[i]) : 4'b0000;
        check($sformatf("d%0d_y", i), 32'(yv[i]), 32'(exp_y));
        check($sformatf("d%0d_busy", i), 32'(bsy[i]), 32'(rem[i] > 0));
        check($sformatf("d%0d_ready", i), 32'(rdy[i]), 32'(rem[i] <= 1));
        check($sformatf("d%0d_done", i), 32'(hd[i]), 32'(done_m[i]));
        check($sformatf("d%0d_onehot", i), 32'($countones(yv[i]) <= 1), 32'd1);
`ifdef DEC2TO4_LOOPBACK_EN
        check($sformatf("d%0d_lb", i), 32'(lb[i]), 32'(rem[i] > 0));
`endif
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_q[$];

  initial begin
    rst  = 1'b1;
    v[0] = 1'b1; c[0] = 2'b11;
    v[1] = 1'b1; c[1] = 2'b11;

    // Reset with a valid code present: nothing may be accepted.
    repeat (3) tick();
    @(negedge clk);
    check("rst_y4", 32'(yv[0]), 32'd0);
    check("rst_busy4", 32'(bsy[0]), 32'd0);
    check("rst_y1", 32'(yv[1]), 32'd0);
    rst  = 1'b0;
    v[0] = 1'b0;
    v[1] = 1'b0;
    #1;
    check("rst_ready4", 32'(rdy[0]), 32'd1);
    tick();

    // Single code 2'b10 with HOLD_CYCLES=4.
    v[0] = 1'b1; c[0] = 2'b10;
    tick();
    v[0] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("single_y", 32'(yv[0]), 32'h4);
      check("single_ready", 32'(rdy[0]), 32'(k == 4));
      check("single_done", 32'(hd[0]), 32'd0);
      tick();
    end
    @(negedge clk);
    check("single_end_y", 32'(yv[0]), 32'd0);
    check("single_end_done", 32'(hd[0]), 32'd1);
    tick();

    // Back-to-back: 2'b01 then 2'b11 held valid.
    v[0] = 1'b1; c[0] = 2'b01;
    tick();
    c[0] = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("b2b_y", 32'(yv[0]), (k <= 4) ? 32'h2 : 32'h8);
      check("b2b_done", 32'(hd[0]), 32'd0);
      tick();
      if (k == 4) v[0] = 1'b0;
    end
    @(negedge clk);
    check("b2b_end_done", 32'(hd[0]), 32'd1);
    tick();

    // Stall: 2'b00 presented during cycle 2 of a hold.
    v[0] = 1'b1; c[0] = 2'b10;
    tick();
    v[0] = 1'b0;
    tick();
    v[0] = 1'b1; c[0] = 2'b00;
    @(negedge clk);
    check("stall_ready_c2", 32'(rdy[0]), 32'd0);
    tick();
    @(negedge clk);
    check("stall_y_c3", 32'(yv[0]), 32'h4);
    tick();
    @(negedge clk);
    check("stall_y_c4", 32'(yv[0]), 32'h4);
    check("stall_ready_c4", 32'(rdy[0]), 32'd1);
    tick();
    v[0] = 1'b0;
    @(negedge clk);
    check("stall_y0", 32'(yv[0]), 32'h1);
    repeat (4) tick();
    @(negedge clk);
    check("stall_done", 32'(hd[0]), 32'd1);
    tick();

    // Reset in cycle 2 of a y3 hold.
    v[0] = 1'b1; c[0] = 2'b11;
    tick();
    v[0] = 1'b0;
    @(negedge clk);
    check("mid_y3", 32'(yv[0]), 32'h8);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_y", 32'(yv[0]), 32'd0);
    check("mid_rst_busy", 32'(bsy[0]), 32'd0);
    check("mid_rst_done", 32'(hd[0]), 32'd0);
    tick();
    @(negedge clk);
    check("mid_rst_done2", 32'(hd[0]), 32'd0);
    v[0] = 1'b1; c[0] = 2'b01;
    tick();
    v[0] = 1'b0;
    @(negedge clk);
    check("mid_next_y", 32'(yv[0]), 32'h2);
    repeat (4) tick();
    @(negedge clk);
    check("mid_next_done", 32'(hd[0]), 32'd1);
    tick();

    // HOLD_CYCLES=1 stream of codes 0..3 on consecutive cycles.
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    for (int k = 0; k < 4; k++) begin
      v[1] = 1'b1; c[1] = 2'(k);
      tick();
      @(negedge clk);
      check("stream_y", 32'(yv[1]), 32'(exp_q.pop_front()));
      check("stream_ready", 32'(rdy[1]), 32'd1);
`ifdef DEC2TO4_LOOPBACK_EN
      check("stream_lb", 32'(lb[1]), 32'd1);
`endif
    end
    v[1] = 1'b0;
    tick();
    @(negedge clk);
    check("stream_done", 32'(hd[1]), 32'd1);
    check("stream_end_y", 32'(yv[1]), 32'd0);
    tick();

    // Randomized traffic; the source holds an unaccepted code.
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!v[i] || acc_m[i]) begin
          v[i] = ($urandom_range(0, 2) != 0);
          c[i] = 2'($urandom_range(0, 3));
        end
      end
      tick();
    end
    rst  = 1'b0;
    v[0] = 1'b0;
    v[1] = 1'b0;
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dec2to4_hold.md
Name: dec2to4_hold

Overview:
- Sequential 2-to-4 decoder: the inverse of the team's 4-to-2 priority encoder (a1 = y3|y2, a0 = y3|(y1&~y2)).
- Accepts a 2-bit code {a1,a0} under a valid/ready handshake.
- Drives the matching registered one-hot line y0..y3 for exactly HOLD_CYCLES clocks, then releases it.
- Used as the select/strobe driver feeding the encoder's inputs, and as the loopback partner for encoder checks.

Parameters:
- HOLD_CYCLES, 4, number of clocks each one-hot output stays asserted. Legal range 1..255.
- CNT_W, 8, width of the hold down-counter. Must satisfy 2**CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- a0  input  1  code bit 0.
- a1  input  1  code bit 1.
- in_valid  input  1  code on a1/a0 is valid.
- in_ready  output  1  block can accept a code this cycle (combinational).
- y0  output  1  one-hot line for code 0, registered.
- y1  output  1  one-hot line for code 1, registered.
- y2  output  1  one-hot line for code 2, registered.
- y3  output  1  one-hot line for code 3, registered.
- busy  output  1  a line is currently being held (state HOLD), registered.
- hold_done  output  1  one-cycle pulse when a hold expires with no back-to-back accept, registered.

Behaviour:
- Reset: on a clk edge with rst=1, state is IDLE, cnt=0, and y0..y3, busy, hold_done are all 0. rst overrides any handshake in the same cycle.
- Reset mid-hold: outputs clear at that edge; no hold_done pulse.
- Accept: an accept occurs when in_valid && in_ready at a rising edge. Code k = {a1,a0} is captured.
- Latency: y_k=1 and busy=1 from the edge of the accept, i.e. visible in the cycle after the handshake. All other y lines are 0.
- States:
  - IDLE: in_ready=1, y all 0. On accept, go to HOLD with cnt=HOLD_CYCLES-1.
  - HOLD: y_k held and in_ready = (cnt==0).
    - cnt>0: cnt decrements each cycle; inputs are ignored.
    - cnt==0, accept: load the new code, reload cnt=HOLD_CYCLES-1, stay in HOLD. This is back-to-back with no gap; a repeated code keeps the same line high continuously.
    - cnt==0, no accept: go to IDLE, clear y and busy, pulse hold_done=1 for one cycle.
- Each accepted code therefore asserts its line for exactly HOLD_CYCLES cycles.
- HOLD_CYCLES=1: in_ready stays 1 throughout, so back-to-back accepts are possible every cycle.
- One-hot invariant: at most one of y0..y3 is high in any cycle, including during code changes.
- in_valid while in_ready=0: the code is not consumed. The source must hold it until ready (no drop, no queue).
- X on a1/a0 when in_valid=0: has no effect.

Optional Feature:
- Macro: DEC2TO4_LOOPBACK_EN.
- Defined: adds output loopback_ok (1 bit, registered, reset 0).
  - Each HOLD cycle, y0..y3 are re-encoded with the encoder equations above and compared to the captured code.
  - loopback_ok=1 when they match, 0 when they mismatch or when not busy.
  - A mismatch also fires an immediate assertion (simulation only).
- Not defined: the port and its logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package dec_pkg holds:
  - state enum (ST_IDLE, ST_HOLD);
  - code constants CODE_Y0..CODE_Y3 = 2'd0..2'd3;
  - function encode4to2(y[3:0]) implementing the encoder equations (used by the loopback check and the bench).
- One natural sub-module: dec2to4_comb, the pure combinational 2-to-4 decode of the code into a 4-bit one-hot vector.
- The top level owns the handshake, FSM, counter and output registers.

Test Plan:
- Reset: rst=1 for 3 cycles with in_valid=1, a1a0=2'b11 -> y0..y3=0, busy=0, in_ready=1 after release; no accept during reset.
- Single code: HOLD_CYCLES=4, accept a1a0=2'b10 -> y2=1 for exactly cycles 1..4, others 0, in_ready=0 during cycles 1..3, hold_done=1 in cycle 5, then IDLE.
- Back-to-back: accept 2'b01, then hold in_valid=1 with 2'b11 -> y1 for 4 cycles then y3 for 4 cycles with no gap; never two lines high; no hold_done between them.
- Stall: present 2'b00 valid during cycle 2 of a hold -> not taken until cnt==0; y0 rises exactly one cycle after that accept edge.
- Mid-hold reset: assert rst at cycle 2 of a y3 hold -> y3=0, busy=0 at that edge, no hold_done; next accept behaves normally.
- HOLD_CYCLES=1 plus DEC2TO4_LOOPBACK_EN: stream codes 0,1,2,3 on consecutive cycles -> y0,y1,y2,y3 each high one cycle; loopback_ok=1 on each cycle of the stream.
